// File: rtl/median_pkg.sv
// Shared constants, state encoding and emit thresholds for the streaming median filter.
package median_pkg;
  localparam int DATA_W = 4;
  localparam int WIN    = 5;

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  localparam logic [2:0] PCNT_MAX      = 3'd4;
  localparam logic [2:0] EMIT_TH_VALID = 3'd3;
  localparam logic [2:0] EMIT_TH_REPL  = 3'd1;
endpackage

// File: rtl/MedianFinder_5num.sv
// Combinational median of five samples; zero latency, no flow control.
module MedianFinder_5num
  import median_pkg::*;
(
  input  logic [DATA_W-1:0] num1,
  input  logic [DATA_W-1:0] num2,
  input  logic [DATA_W-1:0] num3,
  input  logic [DATA_W-1:0] num4,
  input  logic [DATA_W-1:0] num5,
  output logic [DATA_W-1:0] median
);
  logic [DATA_W-1:0] v [WIN];
  assign v[0] = num1;
  assign v[1] = num2;
  assign v[2] = num3;
  assign v[3] = num4;
  assign v[4] = num5;

  // An element is the median when at most two are below it and at least three are not above it.
  always_comb begin
    logic [2:0] lt;
    logic [2:0] le;
    median = v[0];
    for (int i = 0; i < WIN; i++) begin
      lt = 3'd0;
      le = 3'd0;
      for (int j = 0; j < WIN; j++) begin
        if (v[j] < v[i])  lt = lt + 3'd1;
        if (v[j] <= v[i]) le = le + 3'd1;
      end
      if (lt <= 3'd2 && le >= 3'd3) median = v[i];
    end
  end
endmodule

// File: rtl/median_window_shift.sv
// Five-tap sample window; tap[WIN-1] is newest. win is the post-update window, ready the same cycle.
module median_window_shift
  import median_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          load,
  input  logic                          repush,
  input  logic [DATA_W-1:0]             din,
  output logic [WIN-1:0][DATA_W-1:0]    win
);
  logic [WIN-1:0][DATA_W-1:0] tap;
  logic [DATA_W-1:0]          shift_in;

  // repush re-inserts the newest sample, used to pad the trailing edge of a line.
  assign shift_in = repush ? tap[WIN-1] : din;

  always_comb begin
    win = tap;
    if (load) begin
      win = {WIN{din}};
    end else if (push) begin
      for (int i = 0; i < WIN-1; i++) win[i] = tap[i+1];
      win[WIN-1] = shift_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) tap <= '0;
    else     tap <= win;
  end
endmodule

// File: rtl/median_stream_filter.sv
// Streaming 5-tap median filter, 1-cycle latency, stalls input while output is held.
// MEDIAN_EDGE_REPLICATE_EN selects edge-replicated output (one output per input) over valid-window mode.
module median_stream_filter
  import median_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);
  state_t                     state;
  logic [2:0]                 pcnt, pcnt_inc, pcnt_new;
  logic                       slot_free, accept, push, load, repush, emit, last_emit;
  logic [WIN-1:0][DATA_W-1:0] win;
  logic [DATA_W-1:0]          med;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = !rst && (state != FLUSH) && slot_free;
  assign accept    = in_valid && in_ready;

`ifdef MEDIAN_EDGE_REPLICATE_EN
  localparam logic [2:0] EMIT_TH = EMIT_TH_REPL;
  logic flush_cnt;
  assign repush    = (state == FLUSH) && slot_free;
  assign push      = accept || repush;
  assign load      = accept && (state == IDLE);
  assign last_emit = repush && flush_cnt;
`else
  localparam logic [2:0] EMIT_TH = EMIT_TH_VALID;
  assign repush    = 1'b0;
  assign push      = accept;
  assign load      = 1'b0;
  assign last_emit = accept && in_last;
`endif

  // pcnt counts pushes after the one that opens the line, so it is 0 before the second sample.
  assign pcnt_inc = (pcnt >= PCNT_MAX) ? PCNT_MAX : pcnt + 3'd1;
  assign pcnt_new = (state == IDLE) ? 3'd0 : pcnt_inc;
  assign emit     = push && (state != IDLE) && (pcnt >= EMIT_TH);

  median_window_shift u_win (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .load   (load),
    .repush (repush),
    .din    (in_data),
    .win    (win)
  );

  MedianFinder_5num u_med (
    .num1   (win[0]),
    .num2   (win[1]),
    .num3   (win[2]),
    .num4   (win[3]),
    .num5   (win[4]),
    .median (med)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pcnt      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
`ifdef MEDIAN_EDGE_REPLICATE_EN
      flush_cnt <= 1'b0;
`endif
    end else begin
      if (emit) begin
        out_valid <= 1'b1;
        out_data  <= med;
        out_last  <= last_emit;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
`ifdef MEDIAN_EDGE_REPLICATE_EN
      if (repush) begin
        flush_cnt <= ~flush_cnt;
        if (flush_cnt) begin
          state <= IDLE;
          pcnt  <= '0;
        end else begin
          pcnt  <= pcnt_inc;
        end
      end else
`endif
      if (accept) begin
        if (in_last) begin
`ifdef MEDIAN_EDGE_REPLICATE_EN
          state <= FLUSH;
          pcnt  <= pcnt_new;
`else
          state <= IDLE;
          pcnt  <= '0;
`endif
        end else begin
          pcnt  <= pcnt_new;
          state <= (pcnt_new >= EMIT_TH) ? RUN : FILL;
        end
      end
    end
  end
endmodule

// File: tb/tb_median_stream_filter.sv
// Directed scoreboard bench for median_stream_filter; expectations follow MEDIAN_EDGE_REPLICATE_EN.
module tb_median_stream_filter;
  typedef struct packed {
    logic [3:0] data;
    logic       last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_data = 4'd0;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] out_data;
  logic       out_last;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  median_stream_filter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic expect_out(input logic [3:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endtask

  // Called at a falling edge; returns at the falling edge after the sample is accepted.
  task automatic send(input logic [3:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    #1;
    while (!in_ready) begin
      n++;
      if (n > 50) begin
        chk("send_timeout", 0, 1);
        break;
      end
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_ref_line();
    send(4'd3, 1'b0); send(4'd9, 1'b0); send(4'd1, 1'b0); send(4'd7, 1'b0);
    send(4'd5, 1'b0); send(4'd2, 1'b0); send(4'd0, 1'b1);
  endtask

  task automatic expect_ref_line();
`ifdef MEDIAN_EDGE_REPLICATE_EN
    expect_out(4'd3, 1'b0); expect_out(4'd3, 1'b0); expect_out(4'd5, 1'b0);
    expect_out(4'd5, 1'b0); expect_out(4'd2, 1'b0); expect_out(4'd2, 1'b0);
    expect_out(4'd0, 1'b1);
`else
    expect_out(4'd5, 1'b0); expect_out(4'd5, 1'b0); expect_out(4'd2, 1'b1);
`endif
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got data=%0d last=%0d with empty scoreboard", out_data, out_last);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.data || out_last !== e.last) begin
            errors++;
            $display("FAIL out_stream: got data=%0d last=%0d expected data=%0d last=%0d",
                     out_data, out_last, e.data, e.last);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int   t0;
    logic [3:0] held;

    // Reset held for two cycles with a sample offered
    in_valid = 1'b1;
    in_data  = 4'd6;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_last", out_last, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    @(negedge clk);

    // Reference line at full rate
    expect_ref_line();
    t0 = cyc;
    send_ref_line();
    chk("throughput_cycles", cyc - t0, 7);
    repeat (3) @(negedge clk);

    // Three-sample line
`ifdef MEDIAN_EDGE_REPLICATE_EN
    expect_out(4'd4, 1'b0); expect_out(4'd4, 1'b0); expect_out(4'd15, 1'b1);
`endif
    send(4'd4, 1'b0); send(4'd0, 1'b0); send(4'd15, 1'b1);
    #1;
`ifdef MEDIAN_EDGE_REPLICATE_EN
    chk("flush1_in_ready", in_ready, 0);
    @(negedge clk); #1;
    chk("flush2_in_ready", in_ready, 0);
    @(negedge clk); #1;
`endif
    chk("after_line_in_ready", in_ready, 1);
    @(negedge clk);
    repeat (2) @(negedge clk);

    // Reference line with a 3-cycle stall after the fifth sample
    expect_ref_line();
    send(4'd3, 1'b0); send(4'd9, 1'b0); send(4'd1, 1'b0); send(4'd7, 1'b0); send(4'd5, 1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 4'd2;
    #1;
    held = out_data;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_out_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_data", out_data, held);
      @(negedge clk);
    end
    out_ready = 1'b1;
    send(4'd2, 1'b0); send(4'd0, 1'b1);
    repeat (4) @(negedge clk);

    // Short line followed by a five-sample line
`ifdef MEDIAN_EDGE_REPLICATE_EN
    expect_out(4'd1, 1'b0); expect_out(4'd2, 1'b1);
    for (int i = 0; i < 4; i++) expect_out(4'd8, 1'b0);
`endif
    expect_out(4'd8, 1'b1);
    send(4'd1, 1'b0); send(4'd2, 1'b1);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) send(4'd8, 1'b0);
    send(4'd8, 1'b1);
    repeat (4) @(negedge clk);

    // Reset in the middle of a line with an output pending in replicate mode
    send(4'd15, 1'b0); send(4'd14, 1'b0);
    out_ready = 1'b0;
    send(4'd13, 1'b0);
    #1;
`ifdef MEDIAN_EDGE_REPLICATE_EN
    chk("pending_before_rst", out_valid, 1);
`else
    chk("no_output_before_rst", out_valid, 0);
`endif
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    expect_ref_line();
    send_ref_line();
    repeat (6) @(negedge clk);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
